// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch sequencer.
//   state_t : fetch FSM states (IDLE=0, RUN=1, STOP=2)
//   ENTRY_W : width of one prefetch entry {pc, instr}
//   entry_t : packed view of a prefetch entry
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam int ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO, DEPTH x W, synchronous.
//   push/pop : enqueue din / dequeue head; push while full is accepted only with a pop
//   flush    : empties the FIFO, dominates push and pop
//   full, empty, count : occupancy
//   head     : oldest entry, zero when empty
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic          full,
  output logic          empty,
  output logic [PW:0]   count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == DEPTH[PW:0]);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer for a combinational-read word ROM.
//   clk, rst_n        : clock, async active-low reset
//   enable            : fetch allowed (0 pauses pushes, pops continue)
//   redirect_valid/pc : flush prefetch and restart at redirect_pc (low 2 bits dropped)
//   imem_a / imem_rd  : ROM word address (from fetch_pc) / read data
//   inst_valid/ready  : head handshake to the core; inst, inst_pc = head entry
//   stopped           : fetch ran past the ROM (or was redirected outside it)
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int          AW       = 6,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [AW-1:0] imem_a,
  input  logic [31:0]   imem_rd,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst,
  output logic [31:0]   inst_pc,
  output logic          stopped
);

  localparam int PW = $clog2(DEPTH);

  state_t        state, nstate;
  logic [31:0]   fetch_pc;
  logic          in_range, push, pop, full, empty;
  logic [PW:0]   count;
  entry_t        wr_e, head_e;

  // Anything with bits above the ROM's byte range is past the end; no wrap.
  assign in_range = ((fetch_pc >> (AW + 2)) == 32'd0);
  assign imem_a   = fetch_pc[AW+1:2];
  assign pop      = ~empty & inst_ready;
  assign wr_e     = '{pc: fetch_pc, instr: imem_rd};

  always_comb begin
    nstate = state;
    push   = 1'b0;
    if (redirect_valid) begin
      nstate = enable ? ST_RUN : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (enable) nstate = ST_RUN;
        ST_RUN: begin
          if (!enable)        nstate = ST_IDLE;
          else if (!in_range) nstate = ST_STOP;
          else                push   = ~full | pop;
        end
        ST_STOP: ;
        default: nstate = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fetch_pc <= PC_RESET;
    end else begin
      state <= nstate;
      if (redirect_valid) fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (push)      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (wr_e),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head_e)
  );

  assign inst_valid = (count != '0);
  assign inst       = head_e.instr;
  assign inst_pc    = head_e.pc;
  assign stopped    = (state == ST_STOP);

endmodule

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, enable, redirect_valid, inst_ready;
  logic [31:0] redirect_pc, imem_rd, inst, inst_pc;
  logic [5:0]  imem_a;
  logic        inst_valid, stopped;

  always #5 clk = ~clk;

  // 64-word ROM: word i holds A000_0000 | i
  assign imem_rd = 32'hA000_0000 | {26'd0, imem_a};

  ifetch_ctrl #(.AW(6), .DEPTH(4), .PC_RESET(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_a         (imem_a),
    .imem_rd        (imem_rd),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .stopped        (stopped)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queue of pending {pc, instr}, next PC to fetch, mode.
  // mode: 0 = paused, 1 = fetching, 2 = stopped past end of ROM
  logic [63:0] q[$];
  logic [31:0] mpc;
  int          mode;
  logic [31:0] last_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mpc     = 32'h0;
    mode    = 0;
    last_pc = 32'hFFFF_FFFF;
  endtask

  task automatic check_model();
    logic [63:0] h;
    h = (q.size() != 0) ? q[0] : 64'd0;
    chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
    chk("inst",       inst,            h[31:0]);
    chk("inst_pc",    inst_pc,         h[63:32]);
    chk("stopped",    32'(stopped),    32'(mode == 2));
    chk("imem_a",     32'(imem_a),     32'(mpc[7:2]));
  endtask

  task automatic model_update(input bit en, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit taken;
    taken = (q.size() != 0) && rdy;
    if (taken) last_pc = q[0][63:32];
    if (rv) begin
      q.delete();
      mpc  = {rpc[31:2], 2'b00};
      mode = en ? 1 : 0;
    end else begin
      if (taken) void'(q.pop_front());
      if (mode == 0) begin
        if (en) mode = 1;
      end else if (mode == 1) begin
        if (!en) mode = 0;
        else if (mpc >= 32'h100) mode = 2;
        else if (q.size() < 4) begin
          q.push_back({mpc, 32'hA000_0000 | (mpc >> 2)});
          mpc = mpc + 32'd4;
        end
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit en, input bit rv, input logic [31:0] rpc, input bit rdy);
    enable = en; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
    #1;
    check_model();
    @(posedge clk);
    model_update(en, rv, rpc, rdy);
    @(negedge clk);
  endtask

  task automatic reset_cycle();
    rst_n = 1'b0;
    #1;
    chk("rst_valid",   32'(inst_valid), 32'd0);
    chk("rst_inst",    inst,            32'd0);
    chk("rst_pc",      inst_pc,         32'd0);
    chk("rst_stopped", 32'(stopped),    32'd0);
    chk("rst_imem_a",  32'(imem_a),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    model_reset();
    @(negedge clk);
    reset_cycle();

    // 1: first instruction two cycles after enable, then one per cycle
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("first_valid", 32'(inst_valid), 32'd1);
    chk("first_pc",    inst_pc,         32'h0);
    chk("first_inst",  inst,            32'hA000_0000);
    repeat (8) step(1, 0, 0, 1);

    // 2: stall the core; FIFO saturates at PC 0x10
    step(1, 1, 32'h0, 0);
    repeat (10) step(1, 0, 0, 0);
    chk("stall_imem_a", 32'(imem_a), 32'd4);
    chk("stall_head",   inst_pc,     32'h0);
    repeat (8) step(1, 0, 0, 1);

    // 3: redirect while full
    repeat (5) step(1, 0, 0, 0);
    step(1, 1, 32'h0000_0022, 1);
    chk("redir_empty", 32'(inst_valid), 32'd0);
    step(1, 0, 0, 1);
    chk("redir_pc",   inst_pc, 32'h20);
    chk("redir_inst", inst,    32'hA000_0008);

    // 4: run off the end of the ROM
    for (int i = 0; i < 100 && !(mode == 2 && q.size() == 0); i++) step(1, 0, 0, 1);
    repeat (3) step(1, 0, 0, 1);
    chk("eor_stopped", 32'(stopped),    32'd1);
    chk("eor_valid",   32'(inst_valid), 32'd0);
    chk("eor_last",    last_pc,         32'hFC);
    step(1, 1, 32'h4, 1);
    step(1, 0, 0, 1);
    chk("resume_inst", inst, 32'hA000_0001);

    // 5: redirect outside the ROM, then pause mid-stream
    step(1, 1, 32'h100, 1);
    step(1, 0, 0, 1);
    chk("oor_stopped", 32'(stopped),    32'd1);
    chk("oor_valid",   32'(inst_valid), 32'd0);
    step(1, 1, 32'h0, 0);
    repeat (6) step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 1);
    chk("pause_drained", 32'(inst_valid), 32'd0);
    chk("pause_imem_a",  32'(imem_a),     32'd4);

    // 6: reset mid-stream, restart from PC 0
    repeat (5) step(1, 0, 0, 1);
    reset_cycle();
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("restart_pc",   inst_pc, 32'h0);
    chk("restart_inst", inst,    32'hA000_0000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit          en, rv, rdy;
      logic [31:0] rpc;
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? $urandom() : $urandom_range(0, 32'h110);
      step(en, rv, rpc, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
